set_assoc_cache_model: RTL and testbench
========================================

Name: set_assoc_cache_model

Overview:
Parametrised N-way set-associative cache tag model for the memory-hierarchy simulation flow; the direct-mapped case is WAYS=1.
- Accepts one address per request handshake and looks up the tags of all ways.
- On a miss it allocates a victim using invalid-first, then true-LRU selection, and models the block-fill time.
- Reports hit, way and eviction per request and keeps saturating hit, miss and evict statistics counters.

Parameters:
ADDR_W, 32, request address width
SETS, 256, number of sets (power of two, >=1)
WAYS, 4, associativity (power of two, >=1)
BLOCK_BYTES, 64, line size in bytes (power of two); offset bits = clog2(BLOCK_BYTES)
FILL_CYCLES, 4, cycles spent in FILL on a miss (>=1)
COUNT_W, 32, statistics counter width

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  high only in IDLE with flush low
req_addr  in  ADDR_W  byte address: tag | index | offset
flush  in  1  invalidate all lines (sampled in IDLE only)
clear_stats  in  1  zero all counters next edge
resp_valid  out  1  one-cycle completion pulse
resp_hit  out  1  1 = hit, 0 = miss
resp_way  out  max(1,clog2(WAYS))  way hit or filled
resp_evict  out  1  miss replaced a valid line
hit_count  out  COUNT_W  saturating hit total
miss_count  out  COUNT_W  saturating miss total
evict_count  out  COUNT_W  saturating eviction total

Behaviour:
- Reset (rst=1 at an edge, any state):
  - FSM goes to IDLE.
  - All valid bits clear; way i age = i in every set.
  - resp_valid, resp_hit, resp_way, resp_evict = 0; all counters = 0; req_ready = 1 from the next cycle.
  - A request in flight is dropped with no response.
- Address split: offset = addr[OB-1:0], index = addr[OB+IB-1:OB], tag = the remaining upper bits. IB = clog2(SETS), OB = clog2(BLOCK_BYTES).
- FSM IDLE -> LOOKUP -> (RESP | FILL -> RESP) -> IDLE.
  - IDLE, flush=1: clears all valid bits that edge; ages are untouched; req_ready=0; stays in IDLE. Flush has priority over a same-cycle request.
  - IDLE, req_valid & req_ready: registers the address and goes to LOOKUP.
  - LOOKUP: compares all ways, where hit = valid & tag match.
    - Hit: the hit way becomes MRU; go to RESP.
    - Miss: victim = lowest-index invalid way, else the way with age WAYS-1. Go to FILL.
  - FILL: stays FILL_CYCLES cycles, then on the exit edge writes tag, sets valid, makes the victim MRU and goes to RESP. resp_evict = the victim was valid.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Latency for a request accepted at edge T: hit gives resp_valid during cycle T+2; miss gives resp_valid during T+2+FILL_CYCLES. Throughput is one outstanding request, and req_ready=0 outside IDLE.
- LRU: per-set age per way, clog2(WAYS) bits. On access to way w with age a, every way with age < a increments and w becomes 0. Ages form a permutation at all times. With WAYS=1 the ages are absent and the victim is always way 0.
- Counters:
  - Increment on the edge ending the RESP cycle: hit_count on a hit, miss_count on a miss, evict_count when resp_evict=1.
  - Saturate at 2^COUNT_W-1.
  - clear_stats zeroes them and wins over a same-edge increment.
  - flush does not affect counters.
- Requests with req_valid low are ignored; req_addr matters only at the accept edge.

Decomposition:
- Package cache_model_pkg: FSM state enum (IDLE, LOOKUP, FILL, RESP) plus the derived localparam functions for OB, IB, TAG_W and WAY_W.
- Sub-module cache_lru_ages, parametrised on WAYS: holds the age vectors for one indexed set and provides the update-on-access and victim selection.
- Tag/valid arrays and the FSM live in the top module.

Test Plan (defaults: SETS=256, WAYS=4, BLOCK_BYTES=64, FILL_CYCLES=4; set stride 0x4000):
1. After reset, req 0x0000_1000 -> miss, resp_valid at T+6, way 0, evict 0, miss_count=1. Repeat the request -> hit at T+2, way 0, hit_count=1.
2. Reqs 0x0, 0x4000, 0x8000, 0xC000 -> misses into ways 0,1,2,3 with no evict. Then 0x1_0000 -> miss, way 0, resp_evict=1, evict_count=1.
3. Fill set 0 as in scenario 2, hit 0x0 (way 0), then 0x1_0000 -> victim way 1. Then 0x4000 -> miss (evicted line).
4. Hit 0x1000, then pulse flush together with req_valid in IDLE:
   - req_ready=0 that cycle and the request is accepted next cycle.
   - The request misses.
   - hit_count is unchanged at 1.
5. Assert rst during the 2nd FILL cycle -> no resp_valid ever, counters 0. Next req to the same address -> miss.
6. With COUNT_W=4, 20 hits -> hit_count holds 15. clear_stats on the same edge as a hit -> hit_count=0.

Source files
------------

// File: rtl/cache_model_pkg.sv
// Shared definitions for the set-associative cache tag model.
// Contents:
//   cache_state_t  - controller states (IDLE, LOOKUP, FILL, RESP)
//   calc_*         - address-split and way-index width helpers
package cache_model_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_FILL   = 2'd2,
    ST_RESP   = 2'd3
  } cache_state_t;

  // Byte-offset bits within a line.
  function automatic int calc_ob(input int block_bytes);
    return $clog2(block_bytes);
  endfunction

  // Set-index bits taken from the address (0 when SETS == 1).
  function automatic int calc_ib(input int sets);
    return $clog2(sets);
  endfunction

  // Storage width for the set index; never zero so the register is legal.
  function automatic int calc_idx_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

  // Way-number width; a direct-mapped cache still reports a 1-bit way.
  function automatic int calc_way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int sets, input int block_bytes);
    return addr_w - calc_ib(sets) - calc_ob(block_bytes);
  endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// True-LRU age storage and victim selection for every set of the cache.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (ages return to way i = i)
//   i_set        - set being looked up / updated
//   i_valid      - valid bits of that set (invalid ways are preferred victims)
//   i_touch      - access strobe: make i_touch_way the MRU way of i_set
//   i_touch_way  - way being accessed
//   o_victim     - lowest-index invalid way, else the way with the oldest age
module cache_lru_ages
  import cache_model_pkg::*;
#(
  parameter int WAYS = 4,
  parameter int SETS = 256,
  localparam int AW  = calc_way_w(WAYS),
  localparam int IW  = calc_idx_w(SETS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   i_set,
  input  logic [WAYS-1:0] i_valid,
  input  logic            i_touch,
  input  logic [AW-1:0]   i_touch_way,
  output logic [AW-1:0]   o_victim
);

  if (WAYS == 1) begin : g_direct
    // Direct-mapped: no ages, the only way is always the victim.
    logic w_unused_lru;
    assign w_unused_lru = ^{clk, rst, i_set, i_valid, i_touch, i_touch_way};
    assign o_victim     = '0;
  end else begin : g_lru
    logic [AW-1:0] r_age [SETS][WAYS];
    logic [AW-1:0] w_victim;
    logic          w_found;

    // Ages stay a permutation: only ways younger than the touched way age by one.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            r_age[s][w] <= AW'(w);
      end else if (i_touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AW'(w) == i_touch_way)
            r_age[i_set][w] <= '0;
          else if (r_age[i_set][w] < r_age[i_set][i_touch_way])
            r_age[i_set][w] <= r_age[i_set][w] + 1'b1;
        end
      end
    end

    always_comb begin
      w_victim = '0;
      w_found  = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
        if (!w_found && !i_valid[w]) begin
          w_victim = AW'(w);
          w_found  = 1'b1;
        end
      end
      if (!w_found) begin
        for (int w = 0; w < WAYS; w++)
          if (r_age[i_set][w] == AW'(WAYS - 1))
            w_victim = AW'(w);
      end
    end

    assign o_victim = w_victim;
  end

endmodule

// File: rtl/set_assoc_cache_model.sv
// N-way set-associative cache tag model with true-LRU replacement,
// modelled fill latency and saturating statistics counters.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   req_valid/req_ready      - request handshake, req_addr = tag|index|offset
//   flush                    - invalidate every line (honoured in IDLE only)
//   clear_stats              - zero the statistics counters
//   resp_valid               - one-cycle completion pulse with resp_hit/way/evict
//   hit/miss/evict_count     - saturating statistics
module set_assoc_cache_model
  import cache_model_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int SETS        = 256,
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 64,
  parameter int FILL_CYCLES = 4,
  parameter int COUNT_W     = 32,
  localparam int OB         = calc_ob(BLOCK_BYTES),
  localparam int IB         = calc_ib(SETS),
  localparam int IDX_W      = calc_idx_w(SETS),
  localparam int TAG_W      = calc_tag_w(ADDR_W, SETS, BLOCK_BYTES),
  localparam int WAY_W      = calc_way_w(WAYS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               flush,
  input  logic               clear_stats,
  output logic               resp_valid,
  output logic               resp_hit,
  output logic [WAY_W-1:0]   resp_way,
  output logic               resp_evict,
  output logic [COUNT_W-1:0] hit_count,
  output logic [COUNT_W-1:0] miss_count,
  output logic [COUNT_W-1:0] evict_count
);

  localparam int FC_W = $clog2(FILL_CYCLES + 1);

  cache_state_t       r_state;
  logic [TAG_W-1:0]   r_tag;
  logic [IDX_W-1:0]   r_idx;
  logic [TAG_W-1:0]   r_tag_mem [SETS][WAYS];
  logic [WAYS-1:0]    r_valid [SETS];
  logic [FC_W-1:0]    r_fill_cnt;
  logic               r_resp_hit;
  logic               r_resp_evict;
  logic [WAY_W-1:0]   r_resp_way;
  logic [COUNT_W-1:0] r_hit_cnt;
  logic [COUNT_W-1:0] r_miss_cnt;
  logic [COUNT_W-1:0] r_evict_cnt;

  logic [TAG_W-1:0]   w_req_tag;
  logic [IDX_W-1:0]   w_req_idx;
  logic [WAYS-1:0]    w_hit_vec;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic [WAY_W-1:0]   w_victim;
  logic               w_fill_done;
  logic               w_touch;
  logic [WAY_W-1:0]   w_touch_way;
  logic               w_accept;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign w_req_tag = req_addr[ADDR_W-1 -: TAG_W];

  if (IB > 0) begin : g_idx
    assign w_req_idx = req_addr[OB +: IB];
  end else begin : g_no_idx
    assign w_req_idx = '0;
  end

  // The byte offset plays no part in a tag lookup.
  if (OB > 0) begin : g_off
    logic w_unused_offset;
    assign w_unused_offset = ^req_addr[OB-1:0];
  end

  assign req_ready = (r_state == ST_IDLE) && !flush;
  assign w_accept  = req_ready && req_valid;

  always_comb begin
    w_hit_vec = '0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      w_hit_vec[w] = r_valid[r_idx][w] && (r_tag_mem[r_idx][w] == r_tag);
    for (int w = WAYS - 1; w >= 0; w--)
      if (w_hit_vec[w]) w_hit_way = WAY_W'(w);
  end

  assign w_hit       = |w_hit_vec;
  assign w_fill_done = (r_state == ST_FILL) && (r_fill_cnt == FC_W'(FILL_CYCLES - 1));
  // LRU is updated on a lookup hit, or when the filled line becomes resident.
  assign w_touch     = ((r_state == ST_LOOKUP) && w_hit) || w_fill_done;
  assign w_touch_way = (r_state == ST_LOOKUP) ? w_hit_way : r_resp_way;

  cache_lru_ages #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_lru (
    .clk         (clk),
    .rst         (rst),
    .i_set       (r_idx),
    .i_valid     (r_valid[r_idx]),
    .i_touch     (w_touch),
    .i_touch_way (w_touch_way),
    .o_victim    (w_victim)
  );

  // Stage: accept - capture the request address (data, no reset)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_tag <= w_req_tag;
      r_idx <= w_req_idx;
    end
  end

  // Stage: fill completion - tag written into the victim way
  always_ff @(posedge clk) begin
    if (w_fill_done)
      r_tag_mem[r_idx][r_resp_way] <= r_tag;
  end

  // Stage: controller - lookup, victim choice, fill timing, valid bits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_resp_hit   <= 1'b0;
      r_resp_way   <= '0;
      r_resp_evict <= 1'b0;
      r_fill_cnt   <= '0;
      for (int s = 0; s < SETS; s++)
        r_valid[s] <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++)
              r_valid[s] <= '0;
          end else if (req_valid) begin
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_resp_hit   <= 1'b1;
            r_resp_way   <= w_hit_way;
            r_resp_evict <= 1'b0;
            r_state      <= ST_RESP;
          end else begin
            // Victim is held in r_resp_way for the whole fill.
            r_resp_hit   <= 1'b0;
            r_resp_way   <= w_victim;
            r_resp_evict <= r_valid[r_idx][w_victim];
            r_fill_cnt   <= '0;
            r_state      <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_fill_done) begin
            r_valid[r_idx][r_resp_way] <= 1'b1;
            r_state                    <= ST_RESP;
          end else begin
            r_fill_cnt <= r_fill_cnt + 1'b1;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Stage: statistics - counted on the edge that ends the response cycle
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else if (r_state == ST_RESP) begin
      if (r_resp_hit) r_hit_cnt  <= sat_inc(r_hit_cnt);
      else            r_miss_cnt <= sat_inc(r_miss_cnt);
      if (r_resp_evict) r_evict_cnt <= sat_inc(r_evict_cnt);
    end
  end

  assign resp_valid  = (r_state == ST_RESP);
  assign resp_hit    = r_resp_hit;
  assign resp_way    = r_resp_way;
  assign resp_evict  = r_resp_evict;
  assign hit_count   = r_hit_cnt;
  assign miss_count  = r_miss_cnt;
  assign evict_count = r_evict_cnt;

endmodule

// File: tb/tb_set_assoc_cache_model.sv
// Scoreboard bench for set_assoc_cache_model (SETS=256, WAYS=4, 64-byte
// lines, FILL_CYCLES=4, 4-bit counters so saturation is reachable).
module tb_set_assoc_cache_model;

  localparam int FC = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   req_addr;
  logic          flush;
  logic          clear_stats;
  logic          resp_valid;
  logic          resp_hit;
  logic [1:0]    resp_way;
  logic          resp_evict;
  logic [CW-1:0] hit_count;
  logic [CW-1:0] miss_count;
  logic [CW-1:0] evict_count;

  set_assoc_cache_model #(
    .ADDR_W      (32),
    .SETS        (256),
    .WAYS        (4),
    .BLOCK_BYTES (64),
    .FILL_CYCLES (FC),
    .COUNT_W     (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .flush       (flush),
    .clear_stats (clear_stats),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_way    (resp_way),
    .resp_evict  (resp_evict),
    .hit_count   (hit_count),
    .miss_count  (miss_count),
    .evict_count (evict_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       hit;
    logic [1:0] way;
    logic       evict;
    int         cyc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_hit",   resp_hit,   e.hit);
        chk("resp_way",   resp_way,   e.way);
        chk("resp_evict", resp_evict, e.evict);
        chk("resp_cycle", cyc,        e.cyc);
      end
    end
  end

  // acc = cycle counter value just after the accept edge.
  task automatic push_exp(input logic hit, input logic [1:0] way, input logic evict, input int acc);
    exp_t e;
    e.hit   = hit;
    e.way   = way;
    e.evict = evict;
    e.cyc   = acc + 1 + (hit ? 0 : FC);
    q.push_back(e);
  endtask

  // Returns at posedge+2 after the response has been counted.
  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk);
      #2;
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      chk("resp_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic do_req(input logic [31:0] addr, input logic hit, input logic [1:0] way, input logic evict);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    push_exp(hit, way, evict, cyc);
    wait_drain();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    req_valid   = 1'b0;
    req_addr    = '0;
    flush       = 1'b0;
    clear_stats = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst_req_ready",  req_ready,   1);
    chk("rst_resp_valid", resp_valid,  0);
    chk("rst_resp_hit",   resp_hit,    0);
    chk("rst_resp_way",   resp_way,    0);
    chk("rst_resp_evict", resp_evict,  0);
    chk("rst_hit_count",  hit_count,   0);
    chk("rst_miss_count", miss_count,  0);
    chk("rst_evict_count",evict_count, 0);

    // 1: cold miss then hit (set 64, tag 0)
    do_req(32'h0000_1000, 1'b0, 2'd0, 1'b0);
    chk("s1_miss_count", miss_count, 1);
    do_req(32'h0000_1000, 1'b1, 2'd0, 1'b0);
    chk("s1_hit_count", hit_count, 1);

    // 2: fill set 0 in way order, fifth tag evicts LRU way 0
    do_req(32'h0000_0000, 1'b0, 2'd0, 1'b0);
    do_req(32'h0000_4000, 1'b0, 2'd1, 1'b0);
    do_req(32'h0000_8000, 1'b0, 2'd2, 1'b0);
    do_req(32'h0000_C000, 1'b0, 2'd3, 1'b0);
    do_req(32'h0001_0000, 1'b0, 2'd0, 1'b1);
    chk("s2_evict_count", evict_count, 1);
    chk("s2_miss_count",  miss_count,  6);
    chk("s2_hit_count",   hit_count,   1);

    // 3: a hit on way 0 makes way 1 the LRU victim; evicted line then misses
    do_reset();
    do_req(32'h0000_0000, 1'b0, 2'd0, 1'b0);
    do_req(32'h0000_4000, 1'b0, 2'd1, 1'b0);
    do_req(32'h0000_8000, 1'b0, 2'd2, 1'b0);
    do_req(32'h0000_C000, 1'b0, 2'd3, 1'b0);
    do_req(32'h0000_0000, 1'b1, 2'd0, 1'b0);
    do_req(32'h0001_0000, 1'b0, 2'd1, 1'b1);
    do_req(32'h0000_4000, 1'b0, 2'd2, 1'b1);
    chk("s3_hit_count",   hit_count,   1);
    chk("s3_miss_count",  miss_count,  6);
    chk("s3_evict_count", evict_count, 2);

    // 4: flush beats a same-cycle request, request accepted next cycle and misses
    do_reset();
    do_req(32'h0000_1000, 1'b0, 2'd0, 1'b0);
    do_req(32'h0000_1000, 1'b1, 2'd0, 1'b0);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    #1;
    chk("s4_ready_flush", req_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    #1;
    chk("s4_ready_after", req_ready, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    push_exp(1'b0, 2'd0, 1'b0, cyc);
    wait_drain();
    chk("s4_hit_count",  hit_count,  1);
    chk("s4_miss_count", miss_count, 2);

    // 5: reset during the second FILL cycle drops the request
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0000_2000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("s5_hit_count",   hit_count,   0);
    chk("s5_miss_count",  miss_count,  0);
    chk("s5_evict_count", evict_count, 0);
    chk("s5_req_ready",   req_ready,   1);
    repeat (10) @(posedge clk);
    #2;
    do_req(32'h0000_2000, 1'b0, 2'd0, 1'b0);
    chk("s5_miss_after", miss_count, 1);

    // 6: hit counter saturates at 15, clear_stats wins over a same-edge hit
    do_reset();
    do_req(32'h0000_3000, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 20; i++)
      do_req(32'h0000_3000, 1'b1, 2'd0, 1'b0);
    chk("s6_hit_sat",  hit_count,  15);
    chk("s6_miss_one", miss_count, 1);
    req_valid = 1'b1;
    req_addr  = 32'h0000_3000;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    push_exp(1'b1, 2'd0, 1'b0, cyc);
    @(posedge clk);
    #1;
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    #1;
    chk("s6_clear_hit",  hit_count,  0);
    chk("s6_clear_miss", miss_count, 0);
    chk("s6_drained",    q.size(),   0);
    q.delete();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
